// File: rtl/pi_txn_queue.sv
// pi_txn_queue
// Front end between the Raspberry Pi GPIO register interface and the 68000
// bus state machine. The asynchronous Pi strobes are brought into M68K_CLK,
// the four Pi registers are decoded, and complete bus transactions are queued
// in a small circular FIFO. Writes are posted. A read keeps pi_busy high
// until its data returns on done/rdata.
//
// Ports
//   M68K_CLK, M68K_RESET_n   clock, async active-low reset
//   pi_a, pi_wr, pi_rd,      Pi register select, strobes and write data
//   pi_d_in                  (asynchronous to M68K_CLK)
//   pi_d_out, pi_d_oe        Pi read data and its drive enable (combinational)
//   pi_busy                  transaction in progress: FIFO full or read pending
//   ipl_n                    68k interrupt lines, active low
//   reset_req                Pi-requested system reset
//   req_*                    FIFO head presented to the bus state machine
//   req_ack                  pops the head
//   done, rdata              end of the popped cycle, with read data

module pi_txn_queue #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        M68K_CLK,
  input  logic        M68K_RESET_n,
  input  logic [1:0]  pi_a,
  input  logic        pi_wr,
  input  logic        pi_rd,
  input  logic [15:0] pi_d_in,
  output logic [15:0] pi_d_out,
  output logic        pi_d_oe,
  output logic        pi_busy,
  input  logic [2:0]  ipl_n,
  output logic        reset_req,
  output logic        req_valid,
  output logic [22:0] req_addr,
  output logic        req_a0,
  output logic        req_sz,
  output logic        req_rw,
  output logic [15:0] req_wdata,
  input  logic        req_ack,
  input  logic        done,
  input  logic [15:0] rdata
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam logic [2:0]  FULL = 3'(DEPTH);

  // Synchronisers
  logic [2:0]  r_wr_s;
  logic        r_wr_pulse;
  logic [1:0]  r_a_s1, r_a_s2;
  logic [15:0] r_d_s1, r_d_s2;

  // Staging registers
  logic [15:0] r_wstage;
  logic [14:0] r_astage;
  logic        r_a0;

  // FIFO storage and control
  logic [22:0] r_mem_addr  [DEPTH];
  logic        r_mem_a0    [DEPTH];
  logic        r_mem_sz    [DEPTH];
  logic        r_mem_rw    [DEPTH];
  logic [15:0] r_mem_wdata [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [2:0]  r_count;

  // Status / return path
  logic        r_ovf;
  logic        r_rd_out;
  logic        r_busy;
  logic        r_reset_req;
  logic [15:0] r_rlatch;
  logic [2:0]  r_samp;
  logic [2:0]  r_ipl;

  logic        w_wr_edge;
  logic        w_push_req;
  logic        w_full;
  logic        w_push;
  logic        w_pop;
  logic [2:0]  w_next_count;
  logic        w_next_rd_out;

  always_comb begin
    w_wr_edge  = r_wr_s[1] & ~r_wr_s[2];
    w_push_req = r_wr_pulse && (r_a_s2 == 2'd2);
    w_full     = (r_count == FULL);
    w_push     = w_push_req & ~w_full;
    w_pop      = req_ack & (r_count != 3'd0);

    w_next_count = r_count;
    if (w_push && !w_pop)      w_next_count = r_count + 3'd1;
    else if (!w_push && w_pop) w_next_count = r_count - 3'd1;

    // A read pushed in the same cycle as an older read's done stays pending.
    w_next_rd_out = r_rd_out;
    if (done && r_rd_out)      w_next_rd_out = 1'b0;
    if (w_push && r_d_s2[9])   w_next_rd_out = 1'b1;
  end

  // Strobe edge is registered once more so register/FIFO updates land three
  // edges after pi_wr is first sampled.
  always_ff @(posedge M68K_CLK or negedge M68K_RESET_n) begin
    if (!M68K_RESET_n) begin
      r_wr_s     <= '0;
      r_wr_pulse <= 1'b0;
      r_a_s1     <= '0;
      r_a_s2     <= '0;
      r_d_s1     <= '0;
      r_d_s2     <= '0;
    end else begin
      r_wr_s     <= {r_wr_s[1:0], pi_wr};
      r_wr_pulse <= w_wr_edge;
      r_a_s1     <= pi_a;
      r_a_s2     <= r_a_s1;
      r_d_s1     <= pi_d_in;
      r_d_s2     <= r_d_s1;
    end
  end

  always_ff @(posedge M68K_CLK or negedge M68K_RESET_n) begin
    if (!M68K_RESET_n) begin
      r_wstage    <= '0;
      r_astage    <= '0;
      r_a0        <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_rd_out    <= 1'b0;
      r_busy      <= 1'b0;
      r_reset_req <= 1'b0;
      r_rlatch    <= '0;
      r_samp      <= '0;
      r_ipl       <= '0;
    end else begin
      if (r_wr_pulse) begin
        case (r_a_s2)
          2'd0: r_wstage <= r_d_s2;
          2'd1: begin
            r_astage <= r_d_s2[15:1];
            r_a0     <= r_d_s2[0];
          end
          2'd2: if (w_full) r_ovf <= 1'b1;
          default: begin
            r_reset_req <= ~r_d_s2[1];
            if (r_d_s2[2]) r_ovf <= 1'b0;
          end
        endcase
      end

      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count  <= w_next_count;
      r_rd_out <= w_next_rd_out;
      r_busy   <= (w_next_count == FULL) | w_next_rd_out;

      if (done && r_rd_out) r_rlatch <= rdata;

      r_samp <= ~ipl_n;
      if (r_samp == ~ipl_n) r_ipl <= ~ipl_n;
    end
  end

  // Payload storage carries no reset; req_valid qualifies it.
  always_ff @(posedge M68K_CLK) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr]  <= {r_d_s2[7:0], r_astage};
      r_mem_a0[r_wr_ptr]    <= r_a0;
      r_mem_sz[r_wr_ptr]    <= r_d_s2[8];
      r_mem_rw[r_wr_ptr]    <= r_d_s2[9];
      r_mem_wdata[r_wr_ptr] <= r_wstage;
    end
  end

  always_comb begin
    req_valid = (r_count != 3'd0);
    req_addr  = r_mem_addr[r_rd_ptr];
    req_a0    = r_mem_a0[r_rd_ptr];
    req_sz    = r_mem_sz[r_rd_ptr];
    req_rw    = r_mem_rw[r_rd_ptr];
    req_wdata = r_mem_wdata[r_rd_ptr];
    pi_busy   = r_busy;
    reset_req = r_reset_req;
  end

  // Pi read path works directly on the raw pads.
  always_comb begin
    pi_d_out = '0;
    pi_d_oe  = 1'b0;
    case (pi_a)
      2'd0: begin
        pi_d_out = r_rlatch;
        pi_d_oe  = pi_rd;
      end
      2'd3: begin
        pi_d_out = {r_ipl, 8'b0, r_ovf, r_rd_out, r_count};
        pi_d_oe  = pi_rd;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pi_txn_queue.sv
module tb_pi_txn_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  pi_a;
  logic        pi_wr, pi_rd;
  logic [15:0] pi_d_in;
  logic [15:0] pi_d_out;
  logic        pi_d_oe, pi_busy;
  logic [2:0]  ipl_n;
  logic        reset_req, req_valid;
  logic [22:0] req_addr;
  logic        req_a0, req_sz, req_rw;
  logic [15:0] req_wdata;
  logic        req_ack, done;
  logic [15:0] rdata;

  int unsigned n_checks = 0;
  int unsigned n_bad    = 0;
  logic [15:0] rd_val;
  logic        rd_oe;

  always #5 clk = ~clk;

  pi_txn_queue #(.DEPTH(2)) dut (
    .M68K_CLK(clk), .M68K_RESET_n(rst_n),
    .pi_a(pi_a), .pi_wr(pi_wr), .pi_rd(pi_rd), .pi_d_in(pi_d_in),
    .pi_d_out(pi_d_out), .pi_d_oe(pi_d_oe), .pi_busy(pi_busy),
    .ipl_n(ipl_n), .reset_req(reset_req),
    .req_valid(req_valid), .req_addr(req_addr), .req_a0(req_a0),
    .req_sz(req_sz), .req_rw(req_rw), .req_wdata(req_wdata),
    .req_ack(req_ack), .done(done), .rdata(rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pi_write(input logic [1:0] a, input logic [15:0] d);
    pi_a = a; pi_d_in = d;
    tick(3);
    pi_wr = 1'b1;
    tick(4);
    pi_wr = 1'b0;
    tick(3);
  endtask

  task automatic pi_read(input logic [1:0] a, output logic [15:0] d, output logic oe);
    pi_a  = a;
    pi_rd = 1'b1;
    #1;
    d  = pi_d_out;
    oe = pi_d_oe;
    pi_rd = 1'b0;
    #1;
  endtask

  task automatic pulse_ack();
    req_ack = 1'b1;
    tick(1);
    req_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; pi_a = '0; pi_wr = 1'b0; pi_rd = 1'b0; pi_d_in = '0;
    ipl_n = 3'b111; req_ack = 1'b0; done = 1'b0; rdata = '0;
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Reset state
    chk("rst_valid", req_valid, 0);
    chk("rst_busy", pi_busy, 0);
    chk("rst_reset_req", reset_req, 0);
    pi_read(2'd3, rd_val, rd_oe);
    chk("rst_status", rd_val, 16'h0000);
    chk("rst_status_oe", rd_oe, 1);

    // Posted write with edge-exact latency check
    pi_write(2'd0, 16'hBEEF);
    pi_write(2'd1, 16'h1234);
    pi_a = 2'd2; pi_d_in = 16'h00FC;
    tick(3);
    pi_wr = 1'b1;
    tick(3);
    chk("wr_valid_k2", req_valid, 0);
    tick(1);
    chk("wr_valid_k3", req_valid, 1);
    pi_wr = 1'b0;
    tick(3);
    chk("wr_addr", req_addr, 23'h7E091A);
    chk("wr_a0", req_a0, 0);
    chk("wr_sz", req_sz, 0);
    chk("wr_rw", req_rw, 0);
    chk("wr_wdata", req_wdata, 16'hBEEF);
    chk("wr_busy", pi_busy, 0);
    pi_read(2'd3, rd_val, rd_oe);
    chk("wr_status", rd_val, 16'h0001);
    pulse_ack();
    chk("wr_popped", req_valid, 0);

    // Blocking read
    pi_write(2'd2, 16'h0200);
    chk("rd_busy", pi_busy, 1);
    chk("rd_rw", req_rw, 1);
    chk("rd_addr", req_addr, 23'h00091A);
    pi_read(2'd3, rd_val, rd_oe);
    chk("rd_status", rd_val, 16'h0009);
    pulse_ack();
    chk("rd_busy_after_ack", pi_busy, 1);
    tick(2);
    done = 1'b1; rdata = 16'h5A5A;
    tick(1);
    done = 1'b0; rdata = '0;
    chk("rd_busy_after_done", pi_busy, 0);
    pi_read(2'd0, rd_val, rd_oe);
    chk("rd_data", rd_val, 16'h5A5A);
    chk("rd_data_oe", rd_oe, 1);
    pi_read(2'd1, rd_val, rd_oe);
    chk("rd_a1_data", rd_val, 16'h0000);
    chk("rd_a1_oe", rd_oe, 0);

    // Overflow: third push is dropped
    pi_write(2'd0, 16'h1111); pi_write(2'd2, 16'h0010);
    pi_write(2'd0, 16'h2222); pi_write(2'd2, 16'h0011);
    chk("ovf_busy_full", pi_busy, 1);
    pi_write(2'd0, 16'h3333); pi_write(2'd2, 16'h0012);
    pi_read(2'd3, rd_val, rd_oe);
    chk("ovf_status", rd_val, 16'h0012);
    chk("ovf_head_wdata", req_wdata, 16'h1111);
    chk("ovf_head_addr", req_addr, 23'h08091A);
    pi_write(2'd3, 16'h0004);
    pi_read(2'd3, rd_val, rd_oe);
    chk("ovf_cleared", rd_val, 16'h0002);
    chk("reset_req_set", reset_req, 1);
    pi_write(2'd3, 16'h0006);
    chk("reset_req_clr", reset_req, 0);
    pulse_ack();
    chk("pop_head_wdata", req_wdata, 16'h2222);
    chk("pop_head_addr", req_addr, 23'h08891A);
    chk("pop_busy", pi_busy, 0);

    // Simultaneous push and pop at count 1
    pi_write(2'd0, 16'h4444);
    pi_a = 2'd2; pi_d_in = 16'h0013;
    tick(3);
    pi_wr = 1'b1;
    tick(3);
    req_ack = 1'b1;
    tick(1);
    req_ack = 1'b0;
    pi_wr = 1'b0;
    tick(3);
    pi_read(2'd3, rd_val, rd_oe);
    chk("pp_status", rd_val, 16'h0001);
    chk("pp_head_wdata", req_wdata, 16'h4444);
    chk("pp_head_addr", req_addr, 23'h09891A);

    // Reset with two entries queued
    pi_write(2'd0, 16'h5555); pi_write(2'd2, 16'h0014);
    pi_read(2'd3, rd_val, rd_oe);
    chk("q2_status", rd_val, 16'h0002);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", req_valid, 0);
    chk("async_rst_busy", pi_busy, 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // done with no read pending and ack while empty are ignored
    done = 1'b1; rdata = 16'hFFFF;
    req_ack = 1'b1;
    tick(1);
    done = 1'b0; req_ack = 1'b0; rdata = '0;
    tick(1);
    pi_read(2'd0, rd_val, rd_oe);
    chk("idle_done_rlatch", rd_val, 16'h0000);
    pi_read(2'd3, rd_val, rd_oe);
    chk("empty_ack_status", rd_val, 16'h0000);

    // IPL filter
    ipl_n = 3'b000;
    tick(1);
    ipl_n = 3'b111;
    tick(3);
    pi_read(2'd3, rd_val, rd_oe);
    chk("ipl_glitch", rd_val[15:13], 3'd0);
    ipl_n = 3'b010;
    tick(1);
    pi_read(2'd3, rd_val, rd_oe);
    chk("ipl_1cyc", rd_val[15:13], 3'd0);
    tick(1);
    pi_read(2'd3, rd_val, rd_oe);
    chk("ipl_stable", rd_val[15:13], 3'd5);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
